// File: rtl/bcd_step_source.sv
// Upstream digit source for the BCD incrementer / seven-segment chain.
// Advances a 0-9 digit on a debounced button press or a prescaler tick, and pulses carry on the 9->0 wrap.
module bcd_step_source #(
  parameter int unsigned DB_CYCLES = 120000,
  parameter int unsigned TICK_DIV  = 12000000,
  parameter int unsigned CNT_W     = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_step,
  input  logic run_en,
  input  logic clr,
  output logic W,
  output logic X,
  output logic Y,
  output logic Z,
  output logic carry,
  output logic step_ack
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } db_state_e;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  logic [1:0]       sync_q, sync_d;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [3:0]       digit_q, digit_d;
  logic             carry_q, carry_d;
  logic             step_ack_q, step_ack_d;
  logic             btn_s;
  logic             btn_evt;
  logic             tick;
  logic             adv;

  assign sync_d = {sync_q[0], btn_step};
  assign btn_s  = sync_q[1];

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    btn_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d  = WAIT_PRESS;
          db_cnt_d = '0;
        end
      end
      WAIT_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = PRESSED;
          btn_evt = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d  = WAIT_RELEASE;
          db_cnt_d = '0;
        end
      end
      WAIT_RELEASE: begin
        if (btn_s) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          db_cnt_d = db_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Prescaler parks at zero whenever auto-run is off or the digit is cleared.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    tick      = 1'b0;
    if (clr || !run_en) begin
      pre_cnt_d = '0;
    end else if (pre_cnt_q == TICK_LAST) begin
      pre_cnt_d = '0;
      tick      = 1'b1;
    end else begin
      pre_cnt_d = pre_cnt_q + CNT_W'(1);
    end
  end

  assign adv = btn_evt | tick;

  // Out-of-range digit (upset) recovers to 0 on the next advance without a carry.
  always_comb begin
    digit_d    = digit_q;
    carry_d    = 1'b0;
    step_ack_d = 1'b0;
    if (clr) begin
      digit_d = '0;
    end else if (adv) begin
      step_ack_d = 1'b1;
      if (digit_q == 4'd9) begin
        digit_d = '0;
        carry_d = 1'b1;
      end else if (digit_q > 4'd9) begin
        digit_d = '0;
      end else begin
        digit_d = digit_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      state_q    <= IDLE;
      db_cnt_q   <= '0;
      pre_cnt_q  <= '0;
      digit_q    <= '0;
      carry_q    <= 1'b0;
      step_ack_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      pre_cnt_q  <= pre_cnt_d;
      digit_q    <= digit_d;
      carry_q    <= carry_d;
      step_ack_q <= step_ack_d;
    end
  end

  assign W        = digit_q[0];
  assign X        = digit_q[1];
  assign Y        = digit_q[2];
  assign Z        = digit_q[3];
  assign carry    = carry_q;
  assign step_ack = step_ack_q;

endmodule

// File: tb/tb_bcd_step_source.sv
// Bench for bcd_step_source with DB_CYCLES=4, TICK_DIV=8: vector table, hand sequences and a step scoreboard.
module tb_bcd_step_source;

  logic clk = 1'b0;
  logic rst, btn_step, run_en, clr;
  logic W, X, Y, Z, carry, step_ack;
  logic [3:0] dig;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_d  = 0;

  typedef struct {
    logic [3:0] d;
    logic       c;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        run;
    logic        clr;
    int unsigned ncyc;
    logic [3:0]  d;
    logic        c;
    logic        ack;
  } vec_t;
  vec_t vt[14];

  bcd_step_source #(
    .DB_CYCLES(4),
    .TICK_DIV (8),
    .CNT_W    (24)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_step(btn_step),
    .run_en  (run_en),
    .clr     (clr),
    .W       (W),
    .X       (X),
    .Y       (Y),
    .Z       (Z),
    .carry   (carry),
    .step_ack(step_ack)
  );

  always #5 clk = ~clk;
  assign dig = {Z, Y, X, W};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_step();
    sb_t e;
    e.c   = (exp_d == 9);
    exp_d = (exp_d >= 9) ? 0 : exp_d + 1;
    e.d   = 4'(exp_d);
    sb.push_back(e);
  endtask

  task automatic run_ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) push_step();
    run_en = 1'b1;
    cyc(8 * n);
    run_en = 1'b0;
    check("run_ticks_digit", dig, exp_d);
  endtask

  // Every step_ack pulse must match the oldest expected step.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (carry && !step_ack) begin
        checks++;
        errors++;
        $display("FAIL carry_without_ack: carry=1 step_ack=0 at %0t", $time);
      end
      if (step_ack) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_step: step_ack=1 digit=%0d with no step expected at %0t", dig, $time);
        end else begin
          e = sb.pop_front();
          check("sb_digit", dig, e.d);
          check("sb_carry", carry, e.c);
        end
      end
    end
  end

  initial begin
    vt[0]  = '{run: 1'b1, clr: 1'b0, ncyc: 7, d: 4'd7, c: 1'b0, ack: 1'b0};
    vt[1]  = '{run: 1'b1, clr: 1'b0, ncyc: 1, d: 4'd8, c: 1'b0, ack: 1'b1};
    vt[2]  = '{run: 1'b1, clr: 1'b0, ncyc: 1, d: 4'd8, c: 1'b0, ack: 1'b0};
    vt[3]  = '{run: 1'b1, clr: 1'b0, ncyc: 6, d: 4'd8, c: 1'b0, ack: 1'b0};
    vt[4]  = '{run: 1'b1, clr: 1'b0, ncyc: 1, d: 4'd9, c: 1'b0, ack: 1'b1};
    vt[5]  = '{run: 1'b1, clr: 1'b0, ncyc: 7, d: 4'd9, c: 1'b0, ack: 1'b0};
    vt[6]  = '{run: 1'b1, clr: 1'b0, ncyc: 1, d: 4'd0, c: 1'b1, ack: 1'b1};
    vt[7]  = '{run: 1'b1, clr: 1'b0, ncyc: 1, d: 4'd0, c: 1'b0, ack: 1'b0};
    vt[8]  = '{run: 1'b1, clr: 1'b0, ncyc: 7, d: 4'd1, c: 1'b0, ack: 1'b1};
    vt[9]  = '{run: 1'b1, clr: 1'b0, ncyc: 8, d: 4'd2, c: 1'b0, ack: 1'b1};
    vt[10] = '{run: 1'b0, clr: 1'b0, ncyc: 5, d: 4'd2, c: 1'b0, ack: 1'b0};
    vt[11] = '{run: 1'b0, clr: 1'b1, ncyc: 1, d: 4'd0, c: 1'b0, ack: 1'b0};
    vt[12] = '{run: 1'b1, clr: 1'b0, ncyc: 8, d: 4'd1, c: 1'b0, ack: 1'b1};
    vt[13] = '{run: 1'b0, clr: 1'b0, ncyc: 1, d: 4'd1, c: 1'b0, ack: 1'b0};

    rst = 1'b1; btn_step = 1'b0; run_en = 1'b0; clr = 1'b0;
    cyc(2);
    check("reset_digit", dig, 0);
    check("reset_carry", carry, 0);
    check("reset_ack", step_ack, 0);
    rst = 1'b0;
    cyc(2);

    // Clean press held for 20 cycles: one step after 2+4+1 cycles.
    btn_step = 1'b1;
    push_step();
    cyc(6);
    check("press_before_latency", dig, 0);
    cyc(1);
    check("press_digit", dig, 1);
    check("press_ack", step_ack, 1);
    cyc(13);
    check("press_held_digit", dig, 1);
    btn_step = 1'b0;
    cyc(12);
    check("press_release_digit", dig, 1);

    // Bouncy press from 0.
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    exp_d = 0;
    check("clr_digit", dig, 0);
    for (int i = 0; i < 12; i++) begin
      btn_step = ((i % 4) < 2);
      cyc(1);
    end
    check("bounce_no_step", dig, 0);
    btn_step = 1'b1;
    push_step();
    cyc(10);
    btn_step = 1'b0;
    cyc(12);
    check("bounce_digit", dig, 1);

    // Auto-run from 7 via the vector table.
    run_ticks(6);
    for (int i = 0; i < 14; i++) begin
      sb_t e;
      run_en = vt[i].run;
      clr    = vt[i].clr;
      if (vt[i].ack) begin
        e.d = vt[i].d;
        e.c = vt[i].c;
        sb.push_back(e);
      end
      cyc(vt[i].ncyc);
      check($sformatf("vec%0d_digit", i), dig, vt[i].d);
      check($sformatf("vec%0d_carry", i), carry, vt[i].c);
      check($sformatf("vec%0d_ack", i), step_ack, vt[i].ack);
    end
    exp_d = 1;

    // Button event and tick land in the same cycle at digit 4.
    run_ticks(3);
    run_en = 1'b1;
    push_step();
    cyc(1);
    btn_step = 1'b1;
    cyc(6);
    check("coinc_before", dig, 4);
    cyc(1);
    check("coinc_digit", dig, 5);
    check("coinc_ack", step_ack, 1);
    cyc(1);
    check("coinc_ack_single", step_ack, 0);
    check("coinc_digit_after", dig, 5);
    run_en = 1'b0;
    btn_step = 1'b0;
    cyc(12);
    check("coinc_final", dig, 5);

    // clr coincident with a tick at digit 9.
    run_ticks(4);
    run_en = 1'b1;
    cyc(7);
    clr = 1'b1;
    cyc(1);
    check("clr_adv_digit", dig, 0);
    check("clr_adv_carry", carry, 0);
    check("clr_adv_ack", step_ack, 0);
    clr = 1'b0;
    exp_d = 0;
    push_step();
    cyc(7);
    check("post_clr_before_tick", dig, 0);
    cyc(1);
    check("post_clr_tick", dig, 1);
    run_en = 1'b0;
    cyc(1);

    // Async reset mid-qualification at digit 6.
    run_ticks(5);
    btn_step = 1'b1;
    cyc(4);
    rst = 1'b1;
    #1;
    check("rst_async_digit", dig, 0);
    check("rst_async_carry", carry, 0);
    check("rst_async_ack", step_ack, 0);
    cyc(2);
    rst = 1'b0;
    exp_d = 0;
    push_step();
    cyc(6);
    check("rst_requal_before", dig, 0);
    cyc(1);
    check("rst_requal_digit", dig, 1);
    btn_step = 1'b0;
    cyc(12);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
